// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPop    = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
    StParity = 3'd5,
    StStop   = 3'd6
  } uart_state_e;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned STOP_TICKS_DEFAULT = 16;
  localparam logic        LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Tick counter with run-time limit, synchronous clear and a terminal-count strobe.
module uart_bit_timer #(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_tick,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic                 o_terminal
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign o_terminal = i_tick && (cnt_q == (i_limit - 1'b1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (o_terminal) begin
      cnt_d = '0;
    end else if (i_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops words from the TX FIFO and serialises them as UART frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned STOP_TICKS = STOP_TICKS_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_read,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned MAX_TICKS = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_TICKS + 1);
  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  timer_clear;
  logic                  timer_term;
  logic [CNT_WIDTH-1:0]  timer_limit;

  // Only STOP uses a different length; every other bit is OVERSAMPLE ticks.
  assign timer_limit = (state_q == StStop) ? CNT_WIDTH'(STOP_TICKS) : CNT_WIDTH'(OVERSAMPLE);
  assign timer_clear = (state_q == StIdle) || (state_q == StPop) || (state_q == StLoad);

  uart_bit_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bit_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (timer_clear),
    .i_tick     (i_tick),
    .i_limit    (timer_limit),
    .o_terminal (timer_term)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (!i_fifo_empty) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        shreg_d   = i_fifo_data;
        bit_cnt_d = '0;
        tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^i_fifo_data;
`endif
        state_d   = StStart;
      end
      StStart: begin
        if (timer_term) begin
          tx_d    = shreg_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (timer_term) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = LINE_IDLE;
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (timer_term) begin
          tx_d    = LINE_IDLE;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (timer_term) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_fifo_read = (state_q == StPop);
  assign o_busy      = (state_q != StIdle);
  assign o_tx        = tx_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: frame table plus gap, reset and tick-stall sequences.
module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int OS = 16;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       done;

  logic       tick_en;
  logic [1:0] div;
  logic [7:0] fifoq[$];
  int         pops;
  int         dones;
  int         n_cmp;
  int         n_err;

  typedef struct {
    logic [7:0] data;
    logic [0:7] seq;   // data bits in transmit order, hand-written LSB first
    logic       par;
  } vec_t;

  vec_t vecs[6];

  uart_tx_fifo_drain dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_tick       (tick),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_read  (fifo_read),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model and tick generator, all updated on the falling edge.
  initial begin
    div        = '0;
    tick       = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    pops       = 0;
    dones      = 0;
    forever begin
      @(negedge clk);
      if (fifo_read) begin
        pops++;
        if (fifoq.size() > 0) fifo_data = fifoq.pop_front();
      end
      if (done) dones++;
      fifo_empty = (fifoq.size() == 0);
      tick       = tick_en && (div == 2'd3);
      div        = div + 2'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < n * 8 + 100) begin
      @(posedge clk);
      cyc++;
      if (tick) cnt++;
    end
    #1;
    if (cnt < n) check("tick_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fall(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (!tx) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called right after the start-bit falling edge; samples each bit at mid-bit.
  task automatic capture_bits(output logic [0:FL-1] seq);
    wait_ticks(OS / 2);
    seq[0] = tx;
    for (int i = 1; i < FL; i++) begin
      wait_ticks(OS);
      seq[i] = tx;
    end
  endtask

  function automatic logic [0:FL-1] expected_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b0, v.seq, v.par, 1'b1};
`else
    return {1'b0, v.seq, 1'b1};
`endif
  endfunction

  initial begin
    logic [0:FL-1] got;
    logic          ok;
    int            p0;
    int            d0;
    int            bad;
    int            gap;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    tick_en = 1'b1;

    vecs[0] = '{8'h55, 8'b10101010, 1'b0};
    vecs[1] = '{8'hA3, 8'b11000101, 1'b0};
    vecs[2] = '{8'h0F, 8'b11110000, 1'b0};
    vecs[3] = '{8'h07, 8'b11100000, 1'b1};
    vecs[4] = '{8'h03, 8'b11000000, 1'b0};
    vecs[5] = '{8'h80, 8'b00000001, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_read", 32'(fifo_read), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      p0 = pops;
      d0 = dones;
      fifoq.push_back(vecs[i].data);
      wait_fall(ok);
      check("frame_start_seen", 32'(ok), 32'd1);
      if (ok) begin
        capture_bits(got);
        check($sformatf("frame_bits_%02h", vecs[i].data), 32'(got), 32'(expected_frame(vecs[i])));
        wait_done(ok);
        check("frame_done_seen", 32'(ok), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("pops_per_frame", 32'(pops - p0), 32'd1);
        check("dones_per_frame", 32'(dones - d0), 32'd1);
      end
    end

    // Empty FIFO: nothing happens.
    p0  = pops;
    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (fifo_read || !tx || busy) bad++;
    end
    check("empty_idle_violations", 32'(bad), 32'd0);
    check("empty_no_pop", 32'(pops - p0), 32'd0);

    // Back-to-back frames: 0xA3 then 0x0F.
    p0 = pops;
    d0 = dones;
    fifoq.push_back(8'hA3);
    fifoq.push_back(8'h0F);
    wait_fall(ok);
    check("b2b_first_start", 32'(ok), 32'd1);
    if (ok) begin
      capture_bits(got);
      check("b2b_first_bits", 32'(got), 32'(expected_frame(vecs[1])));
      wait_done(ok);
      check("b2b_first_done", 32'(ok), 32'd1);
      gap = 0;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk);
        #1;
        gap++;
        if (!tx) break;
      end
      check("b2b_gap_cycles", 32'(gap), 32'd3);
      capture_bits(got);
      check("b2b_second_bits", 32'(got), 32'(expected_frame(vecs[2])));
      wait_done(ok);
      check("b2b_second_done", 32'(ok), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("b2b_pops", 32'(pops - p0), 32'd2);
      check("b2b_dones", 32'(dones - d0), 32'd2);
    end

    // Reset during data bit 3 of 0x81.
    fifoq.push_back(8'h81);
    wait_fall(ok);
    check("rst_frame_start", 32'(ok), 32'd1);
    wait_ticks(OS / 2 + OS * 4);
    check("rst_bit3_value", 32'(tx), 32'd0);
    check("rst_busy_before", 32'(busy), 32'd1);
    p0 = pops;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx_next_cycle", 32'(tx), 32'd1);
    check("rst_busy_next_cycle", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("rst_no_repop", 32'(pops - p0), 32'd0);
    check("rst_idle_tx", 32'(tx), 32'd1);
    check("rst_idle_busy", 32'(busy), 32'd0);
    fifoq.push_back(8'h55);
    wait_fall(ok);
    check("rst_recover_start", 32'(ok), 32'd1);
    if (ok) begin
      capture_bits(got);
      check("rst_recover_bits", 32'(got), 32'(expected_frame(vecs[0])));
      wait_done(ok);
      check("rst_recover_done", 32'(ok), 32'd1);
    end

    // Tick stall in the middle of the start bit.
    repeat (5) @(posedge clk);
    fifoq.push_back(8'h0F);
    wait_fall(ok);
    check("stall_frame_start", 32'(ok), 32'd1);
    wait_ticks(5);
    tick_en = 1'b0;
    bad = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b0 || !busy) bad++;
    end
    check("stall_tx_held", 32'(bad), 32'd0);
    tick_en = 1'b1;
    wait_ticks(10);
    check("stall_start_tick15", 32'(tx), 32'd0);
    wait_ticks(1);
    check("stall_start_tick16", 32'(tx), 32'd1);
    wait_done(ok);
    check("stall_frame_done", 32'(ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
